// File: rtl/sound_irq_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_irq_pkg
// Brief    : Shared types and defaults for the sound-CPU IRQ sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sound_irq_pkg;

  // Sequencer states; EXPIRED is reachable only in the timeout build.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    ASSERTED = 2'd2,
    EXPIRED  = 2'd3
  } sirq_state_e;

  localparam int DEFAULT_TIMEOUT = 4096;
  localparam int DEFAULT_CNT_W   = 13;

endpackage
`default_nettype wire

// File: rtl/sound_irq_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sound_irq_sched_if
// Brief    : Bus bundle between the main-bus trigger side and the sound IRQ
//            sequencer. master = trigger/clock-enable source, slave = sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface sound_irq_sched_if
  import sound_irq_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             cen_3m;
  logic             n_cen_3m;
  logic             trig;
  logic             z80_n_int;
  logic             busy;
  logic             overrun;
  logic             expired;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output cen_3m, n_cen_3m, trig,
    input  z80_n_int, busy, overrun, expired, hold_cnt
  );

  modport slave (
    input  cen_3m, n_cen_3m, trig,
    output z80_n_int, busy, overrun, expired, hold_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sound_irq_sched_edge_det_cen.sv
`default_nettype none
// ============================================================================
// Module   : edge_det_cen
// Brief    : Clock-enable qualified rising-edge detector with async clear.
//            The sample register only updates on enabled edges, so a level
//            held high over many enables yields a single pulse.
// Revision : 1.0 - initial release
// ============================================================================
module edge_det_cen
  import sound_irq_pkg::*;
(
  input  wire logic clk_i,
  input  wire logic clr_i,
  input  wire logic en_i,
  input  wire logic d_i,
  output logic      rise_o
);
  logic d_q;

  // Sample the input level only on enabled edges; clear drops history.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) d_q <= 1'b0;
    else if (en_i) d_q <= d_i;
  end

  assign rise_o = en_i & d_i & ~d_q;
endmodule
`default_nettype wire

// File: rtl/sound_irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : sound_irq_sched
// Brief    : Sound-CPU (Z80) INT_n sequencer. Catches main-bus trigger
//            writes, re-times them onto the Z80 clock enable, holds INT_n
//            low until acknowledge (sirq_clr), flags overrun.
//            Optional macro SOUND_IRQ_TIMEOUT_EN: drop a request that is
//            never acknowledged after TIMEOUT_CYCLES Z80 ticks.
// Revision : 1.0 - initial release
// ============================================================================
module sound_irq_sched
  import sound_irq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = DEFAULT_CNT_W
)(
  input wire logic          clk_49m,
  input wire logic          sirq_clr,
  sound_irq_sched_if.slave  bus
);
  generate
    if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end
  endgenerate

  sirq_state_e      state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             ovr_q, ovr_d;
  logic             nint_q, nint_d;
  logic             req;
  logic             in_flight;

  edge_det_cen u_trig_edge (
    .clk_i  (clk_49m),
    .clr_i  (sirq_clr),
    .en_i   (bus.cen_3m),
    .d_i    (bus.trig),
    .rise_o (req)
  );

  assign in_flight = (state_q == ARMED) || (state_q == ASSERTED);

`ifdef SOUND_IRQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic exp_q, exp_d;
`endif

  // Next-state and output decode; a re-trigger never disturbs the request in flight.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    nint_d  = nint_q;
    ovr_d   = ovr_q | (req & in_flight);
`ifdef SOUND_IRQ_TIMEOUT_EN
    exp_d   = exp_q;
`endif
    case (state_q)
      IDLE: begin
        nint_d = 1'b1;
        if (req) state_d = ARMED;
      end
      ARMED: begin
        if (bus.n_cen_3m) begin
          state_d = ASSERTED;
          nint_d  = 1'b0;
          hold_d  = '0;
        end
      end
      ASSERTED: begin
        nint_d = 1'b0;
        if (bus.n_cen_3m) begin
`ifdef SOUND_IRQ_TIMEOUT_EN
          if (hold_q == HOLD_LAST) begin
            state_d = EXPIRED;
            nint_d  = 1'b1;
            exp_d   = 1'b1;
          end else if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
          end
`else
          if (hold_q != '1) hold_d = hold_q + 1'b1;
`endif
        end
      end
`ifdef SOUND_IRQ_TIMEOUT_EN
      EXPIRED: begin
        nint_d = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
        nint_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; acknowledge/reset clears everything at once.
  always_ff @(posedge clk_49m or posedge sirq_clr) begin
    if (sirq_clr) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ovr_q   <= 1'b0;
      nint_q  <= 1'b1;
`ifdef SOUND_IRQ_TIMEOUT_EN
      exp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ovr_q   <= ovr_d;
      nint_q  <= nint_d;
`ifdef SOUND_IRQ_TIMEOUT_EN
      exp_q   <= exp_d;
`endif
    end
  end

  assign bus.z80_n_int = nint_q;
  assign bus.busy      = in_flight;
  assign bus.overrun   = ovr_q;
  assign bus.hold_cnt  = hold_q;
`ifdef SOUND_IRQ_TIMEOUT_EN
  assign bus.expired   = exp_q;
`else
  assign bus.expired   = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sound_irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_irq_sched
// Brief    : Directed bench for sound_irq_sched. cen_3m fires at phase 0 and
//            n_cen_3m at phase 8 of a 16-cycle frame unless a step forces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_irq_sched;
  import sound_irq_pkg::*;

  localparam int CW = 13;

  logic clk_49m  = 1'b0;
  logic sirq_clr = 1'b1;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   ph       = 0;
  int   lat;
  logic bad;

  sound_irq_sched_if #(.CNT_W(CW)) bus ();

  sound_irq_sched #(.TIMEOUT_CYCLES(8), .CNT_W(CW)) dut (
    .clk_49m  (clk_49m),
    .sirq_clr (sirq_clr),
    .bus      (bus)
  );

  always #5 clk_49m = ~clk_49m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step_en(input logic c, input logic n);
    bus.cen_3m   = c;
    bus.n_cen_3m = n;
    @(posedge clk_49m);
    #1;
    bus.cen_3m   = 1'b0;
    bus.n_cen_3m = 1'b0;
    ph = (ph + 1) % 16;
  endtask

  task automatic step();
    step_en(ph == 0, ph == 8);
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  task automatic align();
    while (ph != 0) step();
  endtask

  // Mid-cycle acknowledge pulse lasting three clocks.
  task automatic do_ack(input string tag);
    #3 sirq_clr = 1'b1;
    #1;
    chk({tag, "_nint"}, 32'(bus.z80_n_int), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ovr"},  32'(bus.overrun), 32'd0);
    chk({tag, "_hold"}, 32'(bus.hold_cnt), 32'd0);
    steps(3);
    sirq_clr = 1'b0;
  endtask

  initial begin
    bus.trig     = 1'b0;
    bus.cen_3m   = 1'b0;
    bus.n_cen_3m = 1'b0;

    // Reset held while trig toggles and enables fire.
    steps(2);
    bus.trig = 1'b1; steps(20);
    bus.trig = 1'b0; step_en(1'b1, 1'b1);
    bus.trig = 1'b1; step_en(1'b1, 1'b1);
    chk("rst_nint", 32'(bus.z80_n_int), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovr",  32'(bus.overrun), 32'd0);
    chk("rst_hold", 32'(bus.hold_cnt), 32'd0);
    chk("rst_exp",  32'(bus.expired), 32'd0);
    bus.trig = 1'b0;
    step();
    sirq_clr = 1'b0;
    steps(32);
    chk("idle_nint", 32'(bus.z80_n_int), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Single long trigger: one request, INT_n low 8 cycles after it.
    align();
    bus.trig = 1'b1;
    lat = -1;
    bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (lat < 0 && bus.z80_n_int === 1'b0) lat = i;
      else if (lat >= 0 && bus.z80_n_int !== 1'b0) bad = 1'b1;
    end
    chk("single_lat",  32'(lat), 32'd8);
    chk("single_held", 32'(bad), 32'd0);
    chk("single_hold", 32'(bus.hold_cnt), 32'd3);
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_ovr",  32'(bus.overrun), 32'd0);
    bus.trig = 1'b0;
    steps(112);
    chk("hold10", 32'(bus.hold_cnt), 32'd10);
    chk("hold10_nint", 32'(bus.z80_n_int), 32'd0);

    // Acknowledge, then a fresh trigger re-asserts normally.
    do_ack("ack1");
    align();
    bus.trig = 1'b1;
    steps(8);
    chk("rearm_busy", 32'(bus.busy), 32'd1);
    chk("rearm_nint", 32'(bus.z80_n_int), 32'd1);
    step();
    chk("reasrt_nint", 32'(bus.z80_n_int), 32'd0);
    chk("reasrt_hold", 32'(bus.hold_cnt), 32'd0);

    // Second rising edge 200 cycles after the first: overrun only.
    steps(7);
    bus.trig = 1'b0;
    steps(184);
    bus.trig = 1'b1;
    chk("pre_ovr", 32'(bus.overrun), 32'd0);
    steps(8);
    step();
    chk("ovr_set",  32'(bus.overrun), 32'd1);
    chk("ovr_nint", 32'(bus.z80_n_int), 32'd0);
    chk("ovr_busy", 32'(bus.busy), 32'd1);
    bus.trig = 1'b0;
    steps(4);
    do_ack("ack2");
    steps(40);
    chk("noqueue_nint", 32'(bus.z80_n_int), 32'd1);
    chk("noqueue_busy", 32'(bus.busy), 32'd0);

    // Request on the same edge as n_cen_3m: assertion waits for the next one.
    bus.trig = 1'b1;
    step_en(1'b1, 1'b1);
    chk("same_busy", 32'(bus.busy), 32'd1);
    chk("same_nint", 32'(bus.z80_n_int), 32'd1);
    repeat (3) step_en(1'b0, 1'b0);
    chk("same_wait", 32'(bus.z80_n_int), 32'd1);
    step_en(1'b0, 1'b1);
    chk("same_asrt", 32'(bus.z80_n_int), 32'd0);
    chk("same_hold", 32'(bus.hold_cnt), 32'd0);

    // trig still high across acknowledge yields a new request after release.
    do_ack("ack3");
    step_en(1'b1, 1'b0);
    chk("hi_rel_busy", 32'(bus.busy), 32'd1);
    chk("hi_rel_ovr",  32'(bus.overrun), 32'd0);
    step_en(1'b0, 1'b1);
    chk("hi_rel_nint", 32'(bus.z80_n_int), 32'd0);
    bus.trig = 1'b0;

`ifdef SOUND_IRQ_TIMEOUT_EN
    // Eighth n_cen_3m in ASSERTED expires the request.
    repeat (7) step_en(1'b0, 1'b1);
    chk("tmo_hold7", 32'(bus.hold_cnt), 32'd7);
    chk("tmo_pre",   32'(bus.z80_n_int), 32'd0);
    step_en(1'b0, 1'b1);
    chk("tmo_nint", 32'(bus.z80_n_int), 32'd1);
    chk("tmo_exp",  32'(bus.expired), 32'd1);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    step_en(1'b1, 1'b0);
    bus.trig = 1'b1;
    step_en(1'b1, 1'b0);
    repeat (3) step_en(1'b0, 1'b1);
    chk("tmo_ign_busy", 32'(bus.busy), 32'd0);
    chk("tmo_ign_nint", 32'(bus.z80_n_int), 32'd1);
    chk("tmo_ign_ovr",  32'(bus.overrun), 32'd0);
    bus.trig = 1'b0;
    do_ack("ack4");
    chk("tmo_clr_exp", 32'(bus.expired), 32'd0);
`else
    // No timeout: INT_n held, counter saturates.
    repeat (10000) step_en(1'b0, 1'b1);
    chk("sat_hold", 32'(bus.hold_cnt), 32'd8191);
    chk("sat_nint", 32'(bus.z80_n_int), 32'd0);
    chk("sat_exp",  32'(bus.expired), 32'd0);
    chk("sat_busy", 32'(bus.busy), 32'd1);
    do_ack("ack4");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sound_irq_sched.md
Name: sound_irq_sched

Overview:
- Sequences the sound-CPU (Z80) maskable interrupt in the Iron Horse model, between the main MC6809E's sound-IRQ trigger decode and the Z80 INT_n pin.
- Detects trigger writes in the 3.072 MHz main-bus domain and re-times the request onto the Z80 clock enable.
- Holds INT_n low until the Z80 acknowledges, and flags overrun (a re-trigger while a request is in flight).
- Optionally drops a request the Z80 never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 4096, n_cen_3m ticks INT_n may stay low before expiry (used only with the optional feature).
- CNT_W, 13, width of the hold counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_49m  in  1  system clock, 49.152 MHz.
- sirq_clr  in  1  asynchronous active-high reset. Driven as (system reset OR Z80 interrupt acknowledge: M1_n and IORQ_n both low).
- cen_3m  in  1  main-bus clock enable, single clk_49m pulse.
- n_cen_3m  in  1  Z80 clock enable, single clk_49m pulse.
- trig  in  1  main-CPU sound-IRQ write decode; level, may stay high for many clk_49m cycles.
- z80_n_int  out  1  Z80 INT_n, active low.
- busy  out  1  high in ARMED or ASSERTED.
- overrun  out  1  sticky; a trigger rising edge was seen while busy.
- expired  out  1  sticky; the request timed out (optional feature only, else constant 0).
- hold_cnt  out  CNT_W  n_cen_3m ticks spent in ASSERTED, for debug/verification.

Behaviour:
- Reset is sirq_clr, asynchronous, active-high; clock is clk_49m.
- While sirq_clr is high, all of the following hold immediately (no clock needed):
  - state=IDLE, z80_n_int=1, busy=0, overrun=0, expired=0, hold_cnt=0, trig_q=0.
- Trigger sampling:
  - trig_q <= trig only on clk_49m edges where cen_3m=1.
  - A request is a rising edge: trig=1 and trig_q=0 on a cen_3m edge.
  - At most one request per trigger write, however long trig stays high.
- States:
  - IDLE: on a request go to ARMED.
  - ARMED: on the next n_cen_3m edge go to ASSERTED, drive z80_n_int=0 and load hold_cnt=0.
    - A request and n_cen_3m on the same clk_49m edge in IDLE: go to ARMED only; assertion happens on the following n_cen_3m.
  - ASSERTED: z80_n_int=0. hold_cnt increments on each n_cen_3m edge and saturates at 2^CNT_W-1.
    - Exit is via sirq_clr (acknowledge), or via expiry when the optional feature is enabled.
  - EXPIRED (feature only): z80_n_int=1, busy=0. Requests are ignored. Left only via sirq_clr.
- Overrun:
  - A request in ARMED or ASSERTED sets overrun=1.
  - The in-flight request is unchanged; the extra request is not queued.
- Acknowledge:
  - An acknowledge returns the block to IDLE. A trigger whose rising edge falls while sirq_clr is high is lost (matches PCB).
  - trig_q is cleared by reset. A trig still high when sirq_clr deasserts therefore produces a request on the next cen_3m edge.
- Timing:
  - Latency from the request edge to z80_n_int low: 1 to 17 clk_49m cycles (next n_cen_3m strictly after the request edge).
  - z80_n_int is registered, glitch-free.
- Simultaneous events:
  - sirq_clr dominates everything.
  - A request on the same edge as an ARMED→ASSERTED transition counts as overrun.

Optional Feature:
- Macro SOUND_IRQ_TIMEOUT_EN.
- Defined:
  - In ASSERTED, the n_cen_3m edge on which hold_cnt == TIMEOUT_CYCLES-1 moves to EXPIRED and sets expired=1.
  - z80_n_int returns to 1 on that same edge.
- Undefined:
  - No EXPIRED state; INT_n is held indefinitely until acknowledge, as on the original PCB.
  - expired is tied to 0.

Decomposition:
- Package sound_irq_pkg holds:
  - state enum {IDLE, ARMED, ASSERTED, EXPIRED}, 2 bits;
  - localparam DEFAULT_TIMEOUT=4096.
- The sequencer is a single module.
- A sub-module edge_det_cen (enable-qualified rising-edge detector with async clear) is natural and reused for trig.

Test Plan:
- Reset: hold sirq_clr=1, toggle trig → z80_n_int=1, busy=0, overrun=0, hold_cnt=0 throughout; no request after release if trig is low.
- Single trigger: trig high for 64 clk_49m cycles spanning 4 cen_3m pulses → exactly one ARMED→ASSERTED; z80_n_int low within 17 clk_49m cycles; stays low with hold_cnt counting 1,2,3… per n_cen_3m.
- Acknowledge: from ASSERTED at hold_cnt=10, pulse sirq_clr for 3 clk_49m cycles mid-cycle → z80_n_int=1 asynchronously in the same cycle; state=IDLE; next trigger re-asserts normally.
- Overrun: second trig rising edge 200 cycles after the first, before acknowledge → overrun=1; z80_n_int still low; only one acknowledge needed to return to IDLE with overrun=0.
- Same-edge case: request arrives on the clk_49m edge carrying n_cen_3m → z80_n_int falls on the following n_cen_3m, not that edge.
- Timeout (SOUND_IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=8): no acknowledge → z80_n_int rises on the 8th n_cen_3m in ASSERTED, expired=1; further triggers ignored until sirq_clr; without the macro, INT_n is still low after 10000 ticks and hold_cnt reads 8191.
